// File: rtl/msrv_32_store_unit_pkg.sv
// msrv_32_store_unit_pkg: funct3 size codes, FSM state type and lane-mask helper
// shared by the store unit and its alignment/steering block.
`default_nettype none

package msrv_32_store_unit_pkg;

  localparam logic [1:0] F3_SB = 2'b00;
  localparam logic [1:0] F3_SH = 2'b01;
  localparam logic [1:0] F3_SW = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } store_state_e;

  function automatic logic [3:0] lane_mask(input logic [1:0] funct3, input logic [1:0] offset);
    logic [3:0] m;
    m = 4'b0000;
    case (funct3)
      F3_SB:   m = 4'b0001 << offset;
      F3_SH:   m = offset[1] ? 4'b1100 : 4'b0011;
      F3_SW:   m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/msrv_32_store_align.sv
// msrv_32_store_align: combinational alignment check, byte-lane data steering
// and byte-enable generation for one store request.
`default_nettype none

module msrv_32_store_align
  import msrv_32_store_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      i_funct3,
  input  logic [1:0]      i_offset,
  input  logic [XLEN-1:0] i_rs2,
  output logic [XLEN-1:0] o_data,
  output logic [3:0]      o_mask,
  output logic            o_misaligned
);

  always_comb begin
    o_data       = i_rs2;
    o_mask       = lane_mask(i_funct3, i_offset);
    o_misaligned = 1'b0;
    case (i_funct3)
      F3_SB: o_data = {4{i_rs2[7:0]}};
      F3_SH: begin
        o_data       = {2{i_rs2[15:0]}};
        o_misaligned = i_offset[0];
      end
      F3_SW: o_misaligned = |i_offset;
      // funct3=11 is not a store size; flag it the same way as a misaligned access
      default: o_misaligned = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/msrv_32_store_unit.sv
// msrv_32_store_unit: store FSM with req/ready write handshake to data memory.
// Optional write timeout enabled by defining MSRV32_STORE_TIMEOUT_EN.
`default_nettype none

module msrv_32_store_unit
  import msrv_32_store_unit_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            ms_riscv32_mp_clk_in,
  input  logic            ms_riscv32_mp_rst_in,
  input  logic            store_req_in,
  input  logic [1:0]      funct3_in,
  input  logic [XLEN-1:0] iadder_in,
  input  logic [XLEN-1:0] rs2_in,
  input  logic            dmem_ready_in,
  output logic [XLEN-1:0] dmem_addr_out,
  output logic [XLEN-1:0] dmem_wr_data_out,
  output logic [3:0]      dmem_wr_mask_out,
  output logic            dmem_wr_req_out,
  output logic            store_busy_out,
  output logic            store_done_out,
  output logic            misaligned_store_out,
  output logic            store_fault_out
);

  store_state_e    r_state;
  store_state_e    w_next_state;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_data;
  logic [3:0]      r_mask;
  logic            r_req;
  logic            r_done;
  logic            r_mis;
  logic [XLEN-1:0] w_al_data;
  logic [3:0]      w_al_mask;
  logic            w_al_mis;
  logic            w_load;
  logic            w_done;
  logic            w_mis;
  logic            w_timeout_hit;

  msrv_32_store_align #(
    .XLEN(XLEN)
  ) u_align (
    .i_funct3    (funct3_in),
    .i_offset    (iadder_in[1:0]),
    .i_rs2       (rs2_in),
    .o_data      (w_al_data),
    .o_mask      (w_al_mask),
    .o_misaligned(w_al_mis)
  );

`ifdef MSRV32_STORE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_fault;

  assign w_timeout_hit = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) && !dmem_ready_in;

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      r_cnt   <= '0;
      r_fault <= 1'b0;
    end else begin
      r_fault <= (r_state == ST_ISSUE) && w_timeout_hit;
      if (r_state != ST_ISSUE || dmem_ready_in || w_timeout_hit) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign store_fault_out = r_fault;
`else
  assign w_timeout_hit   = 1'b0;
  assign store_fault_out = 1'b0;
`endif

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_done       = 1'b0;
    w_mis        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (store_req_in) begin
          if (w_al_mis) begin
            w_mis = 1'b1;
          end else begin
            w_load       = 1'b1;
            w_next_state = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        // ready on the last allowed cycle wins over the timeout
        if (dmem_ready_in) begin
          w_done       = 1'b1;
          w_next_state = ST_IDLE;
        end else if (w_timeout_hit) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_data  <= '0;
      r_mask  <= '0;
      r_req   <= 1'b0;
      r_done  <= 1'b0;
      r_mis   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_req   <= (w_next_state == ST_ISSUE);
      r_done  <= w_done;
      r_mis   <= w_mis;
      if (w_load) begin
        r_addr <= {iadder_in[XLEN-1:2], 2'b00};
        r_data <= w_al_data;
        r_mask <= w_al_mask;
      end else if (w_next_state == ST_IDLE) begin
        r_mask <= '0;
      end
    end
  end

  assign dmem_addr_out        = r_addr;
  assign dmem_wr_data_out     = r_data;
  assign dmem_wr_mask_out     = r_mask;
  assign dmem_wr_req_out      = r_req;
  assign store_busy_out       = r_req;
  assign store_done_out       = r_done;
  assign misaligned_store_out = r_mis;

endmodule

`default_nettype wire

// File: tb/tb_msrv_32_store_unit.sv
// tb_msrv_32_store_unit: directed spec scenarios plus random traffic checked
// against a transaction-level store model.
`default_nettype none

module tb_msrv_32_store_unit;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic        req;
  logic [1:0]  f3;
  logic [31:0] addr;
  logic [31:0] rs2;
  logic        rdy;
  logic [31:0] o_addr;
  logic [31:0] o_data;
  logic [3:0]  o_mask;
  logic        o_req;
  logic        o_busy;
  logic        o_done;
  logic        o_mis;
  logic        o_fault;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  bit          m_pend;
  bit          m_known;
  int          m_waits;
  logic [31:0] m_addr;
  logic [31:0] m_data;
  logic [3:0]  m_mask;
  bit          m_done;
  bit          m_mis;
  bit          m_fault;

  msrv_32_store_unit #(
    .XLEN(32),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .ms_riscv32_mp_clk_in(clk),
    .ms_riscv32_mp_rst_in(rst),
    .store_req_in        (req),
    .funct3_in           (f3),
    .iadder_in           (addr),
    .rs2_in              (rs2),
    .dmem_ready_in       (rdy),
    .dmem_addr_out       (o_addr),
    .dmem_wr_data_out    (o_data),
    .dmem_wr_mask_out    (o_mask),
    .dmem_wr_req_out     (o_req),
    .store_busy_out      (o_busy),
    .store_done_out      (o_done),
    .misaligned_store_out(o_mis),
    .store_fault_out     (o_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Transaction-level view: a store is legal when its size is 1/2/4 bytes and
  // the address is a multiple of that size; it occupies those bytes of the word.
  task automatic model(input logic r, input logic q, input logic [1:0] fn,
                       input logic [31:0] a, input logic [31:0] d, input logic y);
    int nbytes;
    m_done  = 0;
    m_mis   = 0;
    m_fault = 0;
    if (r) begin
      m_pend = 0; m_known = 1; m_waits = 0;
      m_addr = 0; m_data = 0; m_mask = 0;
    end else if (!m_pend) begin
      if (q) begin
        nbytes = 1 << fn;
        if (fn == 2'b11 || (a % nbytes) != 0) begin
          m_mis = 1;
        end else begin
          m_pend  = 1;
          m_known = 1;
          m_waits = 0;
          m_addr  = a - (a % 4);
          m_mask  = 4'(((1 << nbytes) - 1) << (a % 4));
          if (nbytes == 1)      m_data = (d % 256) * 32'h0101_0101;
          else if (nbytes == 2) m_data = (d % 65536) * 32'h0001_0001;
          else                  m_data = d;
        end
      end
    end else begin
      if (y) begin
        m_pend = 0; m_done = 1; m_known = 0; m_mask = 0;
      end else begin
        m_waits++;
`ifdef MSRV32_STORE_TIMEOUT_EN
        if (m_waits == TO) begin
          m_pend = 0; m_fault = 1; m_known = 0; m_mask = 0; m_waits = 0;
        end
`endif
      end
    end
  endtask

  task automatic compare_all();
    check("req",   {31'd0, o_req},   {31'd0, m_pend});
    check("busy",  {31'd0, o_busy},  {31'd0, m_pend});
    check("mask",  {28'd0, o_mask},  {28'd0, m_mask});
    check("done",  {31'd0, o_done},  {31'd0, m_done});
    check("mis",   {31'd0, o_mis},   {31'd0, m_mis});
    check("fault", {31'd0, o_fault}, {31'd0, m_fault});
    if (m_known) begin
      check("addr", o_addr, m_addr);
      check("data", o_data, m_data);
    end
  endtask

  task automatic do_cycle(input logic r, input logic q, input logic [1:0] fn,
                          input logic [31:0] a, input logic [31:0] d, input logic y);
    rst = r; req = q; f3 = fn; addr = a; rs2 = d; rdy = y;
    @(posedge clk);
    model(r, q, fn, a, d, y);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; f3 = 2'b00; addr = '0; rs2 = '0; rdy = 1'b0;
    m_pend = 0; m_known = 0; m_waits = 0; m_addr = 0; m_data = 0; m_mask = 0;
    do_cycle(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    do_cycle(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    check("reset_addr", o_addr, 32'h0);

    // SB at 0x1003, ready on first ISSUE cycle
    do_cycle(1'b0, 1'b1, 2'b00, 32'h1003, 32'hA5A5_1234, 1'b0);
    check("sb_mask", {28'd0, o_mask}, 32'h8);
    check("sb_data", o_data, 32'h3434_3434);
    check("sb_addr", o_addr, 32'h1000);
    do_cycle(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    check("sb_done", {31'd0, o_done}, 32'h1);
    idle(1);

    // SH at 0x2002, ready after 3 wait cycles
    do_cycle(1'b0, 1'b1, 2'b01, 32'h2002, 32'h0000_BEEF, 1'b0);
    check("sh_mask", {28'd0, o_mask}, 32'hC);
    check("sh_data", o_data, 32'hBEEF_BEEF);
    for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b1, 2'b10, 32'h5550, 32'h1111_1111, 1'b0);
    do_cycle(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    idle(1);

    // misaligned SW, illegal funct3
    do_cycle(1'b0, 1'b1, 2'b10, 32'h3001, 32'h1234_5678, 1'b0);
    check("sw_mis", {31'd0, o_mis}, 32'h1);
    do_cycle(1'b0, 1'b1, 2'b11, 32'h3000, 32'h1234_5678, 1'b0);
    check("f3_mis", {31'd0, o_mis}, 32'h1);
    idle(1);

    // reset on second ISSUE cycle, then late ready
    do_cycle(1'b0, 1'b1, 2'b10, 32'h4000, 32'hDEAD_BEEF, 1'b0);
    do_cycle(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    do_cycle(1'b1, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    check("rst_data", o_data, 32'h0);
    do_cycle(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    check("rst_nodone", {31'd0, o_done}, 32'h0);

    // ready never comes: timeout or indefinite stall
    do_cycle(1'b0, 1'b1, 2'b10, 32'h6000, 32'hCAFE_F00D, 1'b0);
    idle(20);
    do_cycle(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);

    // ready in IDLE is ignored
    idle(1);
    do_cycle(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);
    do_cycle(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      do_cycle(($urandom % 50) == 0, ($urandom % 2) == 0, 2'($urandom),
               $urandom, $urandom, ($urandom % 10) < 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
